// File: rtl/blinker.sv
// Free-running LED blinker: divides clk down to a 50% duty square wave.
// Ports: clk (clock), led (blink output, high = on), rst (async, active-high).
module blinker #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BLINK_HZ    = 1
) (
  input  logic clk,
  output logic led,
  input  logic rst
);

  // Guard the division so a zero BLINK_HZ reaches the check below
  // instead of failing elaboration with a divide-by-zero.
  localparam int HALF_PERIOD =
    (BLINK_HZ > 0) ? CLK_FREQ_HZ / (2 * BLINK_HZ) : 0;

  localparam int CNT_W =
    (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  localparam int LAST_I =
    (HALF_PERIOD > 0) ? HALF_PERIOD - 1 : 0;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_I);

  if (BLINK_HZ == 0) begin : g_bad_blink
    $error("blinker: BLINK_HZ must be non-zero");
  end else if (HALF_PERIOD < 1) begin : g_bad_ratio
    $error("blinker: CLK_FREQ_HZ must be >= 2*BLINK_HZ");
  end

  // Initialisers let the block run with rst never asserted.
  logic [CNT_W-1:0] cnt_q = '0;
  logic             led_q = 1'b0;
  logic [CNT_W-1:0] cnt_d;
  logic             led_d;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    led_d = led_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
      led_d = ~led_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: tb/tb_blinker.sv
// Self-checking bench for blinker: power-up, async reset, minimum divide,
// non-integer ratio and default-width counter.
module tb_blinker;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst10 = 1'b0;
  logic rst2  = 1'b0;
  logic rst11 = 1'b0;
  logic rstd  = 1'b1;
  logic led10, led2, led11, ledd;

  blinker #(.CLK_FREQ_HZ(10), .BLINK_HZ(1)) u10 (
    .clk(clk), .led(led10), .rst(rst10));
  blinker #(.CLK_FREQ_HZ(2), .BLINK_HZ(1)) u2 (
    .clk(clk), .led(led2), .rst(rst2));
  blinker #(.CLK_FREQ_HZ(11), .BLINK_HZ(1)) u11 (
    .clk(clk), .led(led11), .rst(rst11));
  blinker udef (
    .clk(clk), .led(ledd), .rst(rstd));

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  typedef struct {
    logic led;
    int   cnt;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   g      = 0;
  int   k10    = 0;
  int   kd     = 0;
  bit   rd_run = 1'b0;

  task automatic push(input string nm, input logic [31:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] act);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d required an entry", act);
    end else begin
      e = sb.pop_front();
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %0d required %0d", e.nm, act, e.v);
      end
    end
  endtask

  task automatic edge_chk(input bit c10, input logic l10,
                          input int n10, input bit rst_at_edge);
    g++;
    if (rd_run) kd++;
    push("u2_led", 32'(g % 2));
    push("u11_led", 32'((g / 5) % 2));
    push("u11_cnt", 32'(g % 5));
    if (c10) begin
      push("u10_led", 32'(l10));
      push("u10_cnt", 32'(n10));
    end
    if (rd_run) begin
      push("def_led", 32'd0);
      push("def_cnt", 32'(kd));
    end
    @(posedge clk);
    if (rst_at_edge) rst10 = 1'b1;
    #1;
    chk(32'(led2));
    chk(32'(led11));
    chk(32'(u11.cnt_q));
    if (c10) begin
      chk(32'(led10));
      chk(32'(u10.cnt_q));
    end
    if (rd_run) begin
      chk(32'(ledd));
      chk(32'(udef.cnt_q));
    end
  endtask

  task automatic u10_run(input int n);
    for (int i = 0; i < n; i++) begin
      k10++;
      edge_chk(1'b1, logic'((k10 / 5) % 2), k10 % 5, 1'b0);
    end
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 1}; tbl[1] = '{1'b0, 2};
    tbl[2] = '{1'b0, 3}; tbl[3] = '{1'b0, 4};
    tbl[4] = '{1'b1, 0}; tbl[5] = '{1'b1, 1};
    tbl[6] = '{1'b1, 2}; tbl[7] = '{1'b1, 3};
    tbl[8] = '{1'b1, 4}; tbl[9] = '{1'b0, 0};

    #1;
    push("pwrup_led", 32'd0); chk(32'(led10));
    push("pwrup_cnt", 32'd0); chk(32'(u10.cnt_q));
    push("def_rst_led", 32'd0); chk(32'(ledd));
    push("def_rst_cnt", 32'd0); chk(32'(udef.cnt_q));

    for (int i = 0; i < 10; i++)
      edge_chk(1'b1, tbl[i].led, tbl[i].cnt, 1'b0);
    k10 = 10;
    u10_run(90);

    #8;
    rstd   = 1'b0;
    rd_run = 1'b1;
    kd     = 0;

    u10_run(7);
    #8;
    rst10 = 1'b1;
    #1;
    push("async_led", 32'd0); chk(32'(led10));
    push("async_cnt", 32'd0); chk(32'(u10.cnt_q));

    for (int i = 0; i < 20; i++)
      edge_chk(1'b1, 1'b0, 0, 1'b0);
    #8;
    rst10 = 1'b0;
    k10   = 0;
    u10_run(12);

    edge_chk(1'b1, 1'b0, 0, 1'b1);
    edge_chk(1'b1, 1'b0, 0, 1'b0);
    edge_chk(1'b1, 1'b0, 0, 1'b0);
    #8;
    rst10 = 1'b0;
    k10   = 0;
    u10_run(5);

    while (kd < 1000)
      edge_chk(1'b0, 1'b0, 0, 1'b0);
    push("def_final_cnt", 32'd1000); chk(32'(udef.cnt_q));
    push("def_final_led", 32'd0); chk(32'(ledd));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
